// File: rtl/vend_pkg.sv
// Shared definitions for the change dispenser: coin denominations, the
// coin_sel encoding used on the hopper interface, and the payout state enum.
package vend_pkg;

    localparam logic [4:0] DEN_1  = 5'd1;
    localparam logic [4:0] DEN_5  = 5'd5;
    localparam logic [4:0] DEN_10 = 5'd10;
    localparam logic [4:0] DEN_20 = 5'd20;

    typedef enum logic [1:0] {
        COIN_1  = 2'b00,
        COIN_5  = 2'b01,
        COIN_10 = 2'b10,
        COIN_20 = 2'b11
    } coin_sel_t;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        EJECT,
        GAP,
        DONE,
        FAULT
    } state_t;

    // Face value of a coin code, used to debit the balance on each handshake.
    function automatic logic [4:0] coin_value(coin_sel_t sel);
        case (sel)
            COIN_20: return DEN_20;
            COIN_10: return DEN_10;
            COIN_5:  return DEN_5;
            default: return DEN_1;
        endcase
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter with an expiry flag. Counts down on dec and stops at
// zero; expired is high whenever the count is zero. Load wins over dec.
module cycle_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             expired
);

    logic [WIDTH-1:0] count_q;

    // Count register: synchronous reset, load has priority, saturating decrement.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_value;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/change_dispenser.sv
// Pays out a 5-bit balance as a sequence of coin requests to the hopper,
// greedily choosing 20/10/5/1. One request is outstanding at a time; a stalled
// hopper trips a sticky fault that only reset clears.
module change_dispenser
    import vend_pkg::*;
#(
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [4:0] balance_in,
    input  logic       balance_valid,
    input  logic       coin_ready,
    output logic       eject_req,
    output logic [1:0] coin_sel,
    output logic       busy,
    output logic       done,
    output logic [4:0] remaining,
    output logic [2:0] coins_paid,
    output logic       fault
);

    // The gap timer is loaded with GAP_CYCLES-1 and the timeout timer with
    // TIMEOUT-1: the state leaves on the cycle the count is already zero, so a
    // load of N-1 yields exactly N cycles in the waiting state.
    localparam int GAP_W = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);
    localparam int TO_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [TO_W-1:0]  TO_LOAD  = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t     state_q, state_d;
    coin_sel_t  coin_sel_q, sel_code;
    logic [4:0] remaining_q;
    logic [4:0] new_remaining;
    logic [2:0] coins_paid_q;
    logic       zero_done_q;
    logic       handshake;
    logic       load_balance;
    logic       gap_load, gap_dec, gap_expired;
    logic       to_load, to_dec, to_expired;

    assign handshake     = (state_q == EJECT) && coin_ready;
    assign load_balance  = (state_q == IDLE) && balance_valid && (balance_in != 5'd0);
    assign new_remaining = remaining_q - coin_value(coin_sel_q);

    // Largest denomination that still fits the outstanding amount.
    always_comb begin
        if (remaining_q >= DEN_20) begin
            sel_code = COIN_20;
        end else if (remaining_q >= DEN_10) begin
            sel_code = COIN_10;
        end else if (remaining_q >= DEN_5) begin
            sel_code = COIN_5;
        end else begin
            sel_code = COIN_1;
        end
    end

    cycle_timer #(.WIDTH(GAP_W)) u_gap_timer (
        .clock      (clock),
        .reset      (reset),
        .load       (gap_load),
        .load_value (GAP_LOAD),
        .dec        (gap_dec),
        .expired    (gap_expired)
    );

    cycle_timer #(.WIDTH(TO_W)) u_timeout_timer (
        .clock      (clock),
        .reset      (reset),
        .load       (to_load),
        .load_value (TO_LOAD),
        .dec        (to_dec),
        .expired    (to_expired)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and timer controls.
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        gap_load = 1'b0;
        gap_dec  = 1'b0;
        to_load  = 1'b0;
        to_dec   = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_balance) begin
                    state_d = SELECT;
                end
            end
            SELECT: begin
                state_d = EJECT;
                to_load = 1'b1;
            end
            EJECT: begin
                if (coin_ready) begin
                    to_load = 1'b1;
                    if (new_remaining == 5'd0) begin
                        state_d = DONE;
                    end else if (GAP_CYCLES == 0) begin
                        state_d = SELECT;
                    end else begin
                        state_d  = GAP;
                        gap_load = 1'b1;
                    end
                end else if (to_expired) begin
                    state_d = FAULT;
                end else begin
                    to_dec = 1'b1;
                end
            end
            GAP: begin
                if (gap_expired) begin
                    state_d = SELECT;
                end else begin
                    gap_dec = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Payout datapath: balance load, coin choice latch, debit and coin count.
    always_ff @(posedge clock) begin
        if (reset) begin
            remaining_q  <= 5'd0;
            coins_paid_q <= 3'd0;
            coin_sel_q   <= COIN_1;
            zero_done_q  <= 1'b0;
        end else begin
            zero_done_q <= (state_q == IDLE) && balance_valid && (balance_in == 5'd0);
            if (load_balance) begin
                remaining_q  <= balance_in;
                coins_paid_q <= 3'd0;
            end
            if (state_q == SELECT) begin
                coin_sel_q <= sel_code;
            end
            if (handshake) begin
                remaining_q  <= new_remaining;
                coins_paid_q <= coins_paid_q + 3'd1;
            end
        end
    end

    assign eject_req  = (state_q == EJECT);
    assign coin_sel   = coin_sel_q;
    assign busy       = (state_q == SELECT) || (state_q == EJECT) ||
                        (state_q == GAP)    || (state_q == FAULT);
    assign done       = (state_q == DONE) || zero_done_q;
    assign fault      = (state_q == FAULT);
    assign remaining  = remaining_q;
    assign coins_paid = coins_paid_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: a queue-based payout model is
// compared against the DUT every cycle, and directed scenarios pin the model
// with hand-computed coin sequences, timings and fault behaviour.
module tb_change_dispenser;

    localparam int GAP_CYCLES = 2;
    localparam int TIMEOUT    = 16;

    logic       clock = 1'b0;
    logic       reset;
    logic [4:0] balance_in;
    logic       balance_valid;
    logic       coin_ready;
    logic       eject_req;
    logic [1:0] coin_sel;
    logic       busy;
    logic       done;
    logic [4:0] remaining;
    logic [2:0] coins_paid;
    logic       fault;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;
    bit rand_ready = 1'b0;

    change_dispenser #(.GAP_CYCLES(GAP_CYCLES), .TIMEOUT(TIMEOUT)) dut (
        .clock         (clock),
        .reset         (reset),
        .balance_in    (balance_in),
        .balance_valid (balance_valid),
        .coin_ready    (coin_ready),
        .eject_req     (eject_req),
        .coin_sel      (coin_sel),
        .busy          (busy),
        .done          (done),
        .remaining     (remaining),
        .coins_paid    (coins_paid),
        .fault         (fault)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Coin value to hopper code mapping: 1->00, 5->01, 10->10, 20->11.
    function automatic int code_of(input int v);
        case (v)
            20:      return 3;
            10:      return 2;
            5:       return 1;
            default: return 0;
        endcase
    endfunction

    // ---------------- behavioural model ----------------
    // The payout is a queue of coin values; after each accepted coin the next
    // request appears GAP_CYCLES+1 cycles later (gap plus selection cycle).
    int m_q[$];
    int m_rem, m_paid, m_wait, m_stall;
    bit m_busy, m_req, m_done, m_done_pay, m_fault;
    bit m_was_done_pay;

    always @(posedge clock) begin
        cyc++;
        if (reset) begin
            m_q.delete();
            m_rem = 0; m_paid = 0; m_wait = 0; m_stall = 0;
            m_busy = 0; m_req = 0; m_done = 0; m_done_pay = 0; m_fault = 0;
        end else begin
            m_was_done_pay = m_done_pay;
            m_done = 0;
            m_done_pay = 0;
            if (m_fault) begin
                // frozen until reset
            end else if (m_req) begin
                if (coin_ready) begin
                    m_rem  = m_rem - m_q[0];
                    void'(m_q.pop_front());
                    m_paid = m_paid + 1;
                    m_req  = 0;
                    if (m_q.size() == 0) begin
                        m_busy = 0; m_done = 1; m_done_pay = 1;
                    end else begin
                        m_wait = GAP_CYCLES + 1;
                    end
                end else begin
                    m_stall++;
                    if (m_stall == TIMEOUT) begin
                        m_fault = 1; m_req = 0;
                    end
                end
            end else if (m_busy) begin
                m_wait--;
                if (m_wait == 0) begin
                    m_req = 1; m_stall = 0;
                end
            end else if (!m_was_done_pay && balance_valid) begin
                if (balance_in == 0) begin
                    m_done = 1;
                end else begin
                    int b;
                    b = balance_in;
                    m_q.delete();
                    while (b >= 20) begin m_q.push_back(20); b -= 20; end
                    while (b >= 10) begin m_q.push_back(10); b -= 10; end
                    while (b >= 5)  begin m_q.push_back(5);  b -= 5;  end
                    while (b >= 1)  begin m_q.push_back(1);  b -= 1;  end
                    m_rem = balance_in; m_paid = 0; m_busy = 1; m_wait = 1;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        if (chk_en) begin
            check("eject_req",  eject_req,  m_req);
            check("busy",       busy,       m_busy);
            check("done",       done,       m_done);
            check("fault",      fault,      m_fault);
            check("remaining",  remaining,  m_rem);
            check("coins_paid", coins_paid, m_paid);
            if (m_req) check("coin_sel", coin_sel, code_of(m_q[0]));
        end
    end

    // Record each handshake: coin codes packed two bits each, plus timing.
    int obs_n, obs_code, t_first, t_last;
    always @(negedge clock) begin
        if (chk_en && !reset && eject_req && coin_ready) begin
            obs_code = obs_code * 4 + coin_sel;
            if (obs_n == 0) t_first = cyc;
            t_last = cyc;
            obs_n++;
        end
    end

    task automatic obs_clear();
        obs_n = 0; obs_code = 0; t_first = 0; t_last = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        if (rand_ready) coin_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic pulse_valid(input logic [4:0] b);
        balance_in = b;
        balance_valid = 1'b1;
        tick();
        balance_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 200; i++) begin
            tick();
            if (done) break;
        end
        check({name, " done reached"}, done, 1);
    endtask

    task automatic wait_req(input string name);
        for (int i = 0; i < 20; i++) begin
            if (eject_req) break;
            tick();
        end
        check({name, " eject_req reached"}, eject_req, 1);
    endtask

    initial begin
        reset = 1'b1; balance_valid = 1'b0; balance_in = 5'd0; coin_ready = 1'b1;
        obs_clear();
        @(posedge clock); #1;
        chk_en = 1'b1;
        tick();
        check("reset eject_req",  eject_req,  0);
        check("reset busy",       busy,       0);
        check("reset remaining",  remaining,  0);
        check("reset coins_paid", coins_paid, 0);
        check("reset fault",      fault,      0);
        check("reset coin_sel",   coin_sel,   0);
        reset = 1'b0;
        tick();

        // 30 with ready high: 20 then 10, handshakes 4 edges apart.
        obs_clear();
        pulse_valid(5'd30);
        wait_done("bal30");
        check("bal30 coin count", obs_n, 2);
        check("bal30 coin codes", obs_code, 'b1110);
        check("bal30 handshake spacing", t_last - t_first, GAP_CYCLES + 2);
        check("bal30 coins_paid", coins_paid, 2);
        check("bal30 remaining", remaining, 0);
        check("bal30 busy at done", busy, 0);
        tick();

        // 31: 20, 10, 1.
        obs_clear();
        pulse_valid(5'd31);
        wait_done("bal31");
        check("bal31 coin codes", obs_code, 'b111000);
        check("bal31 coins_paid", coins_paid, 3);
        tick();

        // 25: 20, 5.
        obs_clear();
        pulse_valid(5'd25);
        wait_done("bal25");
        check("bal25 coin codes", obs_code, 'b1101);
        check("bal25 coins_paid", coins_paid, 2);
        tick();

        // Zero balance: done exactly one cycle after the strobe, no ejection.
        pulse_valid(5'd0);
        check("bal0 done", done, 1);
        check("bal0 busy", busy, 0);
        check("bal0 eject_req", eject_req, 0);
        tick();
        check("bal0 done single cycle", done, 0);

        // Stalled hopper on 10: fault after the timeout, later valid ignored.
        coin_ready = 1'b0;
        pulse_valid(5'd10);
        repeat (TIMEOUT + 4) tick();
        check("stall fault", fault, 1);
        check("stall eject_req", eject_req, 0);
        check("stall remaining", remaining, 10);
        check("stall busy", busy, 1);
        pulse_valid(5'd5);
        repeat (4) tick();
        check("fault ignores valid remaining", remaining, 10);
        check("fault still set", fault, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        coin_ready = 1'b1;
        check("fault cleared by reset", fault, 0);
        tick();

        // 20 with a 5-cycle stall: coin_sel held, one ejection, no fault.
        obs_clear();
        coin_ready = 1'b0;
        pulse_valid(5'd20);
        wait_req("bal20");
        repeat (4) tick();
        check("bal20 stall coin_sel", coin_sel, 3);
        coin_ready = 1'b1;
        wait_done("bal20");
        check("bal20 coin codes", obs_code, 3);
        check("bal20 coin count", obs_n, 1);
        check("bal20 fault", fault, 0);
        tick();

        // Reset in the middle of EJECT for 15, then a fresh payout of 5.
        coin_ready = 1'b0;
        pulse_valid(5'd15);
        wait_req("bal15");
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort eject_req", eject_req, 0);
        check("abort remaining", remaining, 0);
        check("abort busy", busy, 0);
        coin_ready = 1'b1;
        obs_clear();
        pulse_valid(5'd5);
        wait_done("bal5");
        check("bal5 coin codes", obs_code, 1);
        check("bal5 coin count", obs_n, 1);
        check("bal5 coins_paid", coins_paid, 1);
        tick();

        // Random traffic: strobes at any time, random hopper readiness.
        rand_ready = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            reset = fault;
            balance_valid = ($urandom_range(0, 4) == 0);
            balance_in = 5'($urandom_range(0, 31));
            tick();
        end
        reset = 1'b0;
        balance_valid = 1'b0;
        rand_ready = 1'b0;
        coin_ready = 1'b1;
        repeat (60) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
